// File: rtl/multisim_rw_mem_agent_if.sv
// Command/response handshake bundle between the rw_cmd pull server, the memory agent
// and the rw_rsp push server.
interface multisim_rw_mem_agent_if;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [191:0] cmd;
    logic         rsp_vld;
    logic         rsp_rdy;
    logic [63:0]  rsp;

    modport master (output cmd_vld, cmd, rsp_rdy, input cmd_rdy, rsp_vld, rsp);
    modport slave  (input cmd_vld, cmd, rsp_rdy, output cmd_rdy, rsp_vld, rsp);
endinterface

// File: rtl/multisim_rw_mem_agent.sv
// Read/write memory agent: executes 192-bit commands against a 64-bit memory and queues
// one response per command. Define MULTISIM_RW_MEM_ADDR_CHECK_EN to flag out-of-range addresses.
module multisim_rw_mem_agent #(
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    multisim_rw_mem_agent_if.slave        bus,
    output logic [31:0]                   rd_count,
    output logic [31:0]                   wr_count,
    output logic [31:0]                   err_count
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [63:0]   BAD_RD  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic [63:0]           mem  [2**ADDR_WIDTH];
    logic [63:0]           fifo [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  rwb_p0;
    logic                  oor_p0;
    logic                  accept_p0;
    logic                  pop_p0;
    logic [ADDR_WIDTH-1:0] idx_p0;
    logic [63:0]           rsp_data_p0;
    logic                  unused_cmd_bits;

    assign rwb_p0 = bus.cmd[0];
    assign idx_p0 = bus.cmd[64 +: ADDR_WIDTH];
    assign unused_cmd_bits = ^{bus.cmd[63:1], bus.cmd[127:64+ADDR_WIDTH]};

`ifdef MULTISIM_RW_MEM_ADDR_CHECK_EN
    assign oor_p0 = |bus.cmd[127:64+ADDR_WIDTH];
`else
    assign oor_p0 = 1'b0;
`endif

    // Ready depends only on registered occupancy; held high throughout reset.
    assign bus.cmd_rdy = rst | (fifo_count < DEPTH_C);
    assign accept_p0   = bus.cmd_vld & bus.cmd_rdy & ~rst;
    assign bus.rsp_vld = (fifo_count != '0);
    assign pop_p0      = bus.rsp_vld & bus.rsp_rdy;
    assign bus.rsp     = bus.rsp_vld ? fifo[rd_ptr] : 64'h0;

    always_comb begin
        rsp_data_p0 = 64'h0;
        if (rwb_p0) rsp_data_p0 = oor_p0 ? BAD_RD : mem[idx_p0];
    end

    // Stage p0 -> storage: memory update and response capture at the accept edge
    always_ff @(posedge clk) begin
        if (accept_p0 && !rwb_p0 && !oor_p0) mem[idx_p0] <= bus.cmd[191:128];
        if (accept_p0) fifo[wr_ptr] <= rsp_data_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            if (accept_p0) wr_ptr <= wr_ptr + 1'b1;
            if (pop_p0)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept_p0, pop_p0})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (accept_p0 && rwb_p0)  rd_count <= rd_count + 32'd1;
            if (accept_p0 && !rwb_p0) wr_count <= wr_count + 32'd1;
        end
    end

`ifdef MULTISIM_RW_MEM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                      err_count <= '0;
        else if (accept_p0 && oor_p0) err_count <= err_count + 32'd1;
    end
`else
    assign err_count = 32'h0;
`endif
endmodule

// File: tb/tb_multisim_rw_mem_agent.sv
// Bench for multisim_rw_mem_agent: directed table, corner sequences and random traffic
// checked against a queue/array reference model.
module tb_multisim_rw_mem_agent;
    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_count, wr_count, err_count;
    always #5 clk = ~clk;

    multisim_rw_mem_agent_if bus();

    multisim_rw_mem_agent #(.ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
    );

    // Reference model state
    logic [63:0] mmem [2**AW];
    logic [63:0] expq [$];
    logic [31:0] m_rd, m_wr, m_err;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          vld;
        bit          rd;
        logic [63:0] addr;
        logic [63:0] data;
        bit          rrdy;
        bit          e_rdy;
        bit          e_vld;
        logic [63:0] e_rsp;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic step(input bit r, input bit vld, input bit rd, input logic [63:0] addr,
                        input logic [63:0] data, input bit rrdy, output bit acc);
        int          sz;
        bit          oor;
        logic [63:0] v;
        rst         = r;
        bus.cmd_vld = vld;
        bus.cmd     = {data, addr, 63'h0, rd};
        bus.rsp_rdy = rrdy;
        #1;
        sz = expq.size();
        check("cmd_rdy",   bus.cmd_rdy, r || (sz < DEPTH));
        check("rsp_vld",   bus.rsp_vld, sz != 0);
        check("rsp",       bus.rsp, (sz != 0) ? expq[0] : 64'h0);
        check("rd_count",  rd_count, m_rd);
        check("wr_count",  wr_count, m_wr);
        check("err_count", err_count, m_err);
        acc = 1'b0;
        if (r) begin
            expq.delete();
            m_rd = 0; m_wr = 0; m_err = 0;
        end else begin
            if (sz != 0 && rrdy) void'(expq.pop_front());
            acc = vld && (sz < DEPTH);
            if (acc) begin
`ifdef MULTISIM_RW_MEM_ADDR_CHECK_EN
                oor = (addr >> AW) != 64'h0;
`else
                oor = 1'b0;
`endif
                if (oor) m_err = m_err + 1;
                if (rd) begin
                    v = oor ? 64'hDEAD_BEEF_DEAD_BEEF : mmem[addr % (2**AW)];
                    m_rd = m_rd + 1;
                end else begin
                    v = 64'h0;
                    if (!oor) mmem[addr % (2**AW)] = data;
                    m_wr = m_wr + 1;
                end
                expq.push_back(v);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit          a;
        int          acc_n;
        logic [63:0] ra [4];
        m_rd = 0; m_wr = 0; m_err = 0;
        rst = 1'b1; bus.cmd_vld = 1'b0; bus.cmd = '0; bus.rsp_rdy = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, a);
        step(1, 0, 0, 0, 0, 0, a);
        check("reset_rsp_vld", bus.rsp_vld, 0);
        check("reset_rsp", bus.rsp, 0);
        check("reset_cmd_rdy", bus.cmd_rdy, 1);

        // Directed table: write/read, back-to-back write then read
        vt[0] = '{1, 0, 64'h05, 64'h1122334455667788, 1, 1, 0, 64'h0};
        vt[1] = '{1, 1, 64'h05, 64'h0,                1, 1, 1, 64'h0};
        vt[2] = '{1, 0, 64'h10, 64'hA,                1, 1, 1, 64'h1122334455667788};
        vt[3] = '{1, 1, 64'h10, 64'h0,                1, 1, 1, 64'h0};
        vt[4] = '{0, 0, 64'h00, 64'h0,                1, 1, 1, 64'hA};
        vt[5] = '{0, 0, 64'h00, 64'h0,                1, 1, 0, 64'h0};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tbl%0d_cmd_rdy", i), bus.cmd_rdy, vt[i].e_rdy);
            check($sformatf("tbl%0d_rsp_vld", i), bus.rsp_vld, vt[i].e_vld);
            check($sformatf("tbl%0d_rsp", i),     bus.rsp,     vt[i].e_rsp);
            step(0, vt[i].vld, vt[i].rd, vt[i].addr, vt[i].data, vt[i].rrdy, a);
            if (i < 4) check($sformatf("tbl%0d_accepted", i), a, 1);
        end
        check("tbl_wr_count", wr_count, 2);
        check("tbl_rd_count", rd_count, 2);

        // Backpressure: only DEPTH reads accepted while rsp_rdy is low
        ra[0] = 64'h05; ra[1] = 64'h10; ra[2] = 64'h05; ra[3] = 64'h10;
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, acc_n < 4, 1, ra[acc_n & 3], 0, 0, a);
            if (a) acc_n++;
        end
        check("bp_accepted", acc_n, 2);
        check("bp_cmd_rdy", bus.cmd_rdy, 0);
        for (int c = 0; c < 20 && (acc_n < 4 || expq.size() != 0); c++) begin
            step(0, acc_n < 4, 1, ra[acc_n & 3], 0, 1, a);
            if (a) acc_n++;
        end
        check("bp_all_accepted", acc_n, 4);
        check("bp_drained", expq.size(), 0);

        // Reset with two responses pending; command in the reset cycle must not execute
        step(0, 1, 0, 64'h20, 64'h55, 0, a);
        step(0, 1, 0, 64'h21, 64'h66, 0, a);
        step(1, 1, 0, 64'h20, 64'h99, 0, a);
        check("rst_rsp_vld", bus.rsp_vld, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        step(0, 1, 1, 64'h20, 0, 1, a);
        check("rst_persist", bus.rsp, 64'h55);
        step(0, 0, 0, 0, 0, 1, a);

        // Out-of-range / aliased read
        step(0, 1, 0, 64'h03, 64'h3333, 1, a);
        step(0, 1, 1, 64'h1_0000_0003, 0, 1, a);
`ifdef MULTISIM_RW_MEM_ADDR_CHECK_EN
        check("oor_rsp", bus.rsp, 64'hDEAD_BEEF_DEAD_BEEF);
        check("oor_err_count", err_count, 1);
`else
        check("alias_rsp", bus.rsp, 64'h3333);
        check("alias_err_count", err_count, 0);
`endif
        step(0, 0, 0, 0, 0, 1, a);

        // Write counter wrap
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        m_wr = 32'hFFFF_FFFF;
        check("wrap_preload", wr_count, 32'hFFFF_FFFF);
        step(0, 1, 0, 64'h07, 64'h77, 1, a);
        check("wrap_wr_count", wr_count, 0);

        // Random traffic over a pre-initialised window
        for (int i = 0; i < 16; i++) step(0, 1, 0, i, {$urandom, $urandom}, 1, a);
        for (int i = 0; i < 400; i++) begin
            logic [63:0] ad;
            ad = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ad[40] = 1'b1;
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ad,
                 {$urandom, $urandom}, $urandom_range(0, 3) != 0, a);
        end
        for (int c = 0; c < 10 && expq.size() != 0; c++) step(0, 0, 0, 0, 0, 1, a);
        check("rand_drained", expq.size(), 0);
        check("final_rsp_vld", bus.rsp_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
